// File: rtl/dense_backward.sv
// rtl/dense_backward.sv - dense layer backward pass (dX and dW) on a single time-shared MAC.
module dense_backward #(
  parameter int B     = 2,
  parameter int M     = 3,
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] weights  [M][N],
  input  logic signed [WIDTH-1:0] inputs   [B][N],
  input  logic signed [WIDTH-1:0] grad_out [B][M],
  output logic signed [WIDTH-1:0] grad_in  [B][N],
  output logic signed [WIDTH-1:0] grad_w   [M][N],
  output logic                    busy,
  output logic                    done
);

  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(B - 1);
  localparam logic [MW-1:0] M_LAST = MW'(M - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);

  typedef enum logic [1:0] {IDLE, DX, DW, FIN} state_t;

  state_t state, state_next;

  logic [BW-1:0] bi;
  logic [MW-1:0] mi;
  logic [NW-1:0] ni;
  logic          b_last, m_last, n_last;

  logic signed [WIDTH-1:0] cap_w  [M][N];
  logic signed [WIDTH-1:0] cap_x  [B][N];
  logic signed [WIDTH-1:0] cap_dy [B][M];

  logic signed [WIDTH-1:0]   mul_a, mul_b;
  logic signed [2*WIDTH-1:0] prod, acc, sum, shifted;
  logic signed [WIDTH-1:0]   result;

  assign b_last = (bi == B_LAST);
  assign m_last = (mi == M_LAST);
  assign n_last = (ni == N_LAST);

  // dY[b][i] is a factor in both passes; only the second operand is switched.
  assign mul_a   = cap_dy[bi][mi];
  assign mul_b   = (state == DW) ? cap_x[bi][ni] : cap_w[mi][ni];
  assign prod    = mul_a * mul_b;
  assign sum     = acc + prod;
  assign shifted = sum >>> FRAC;
  assign result  = shifted[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = DX;
      DX:   if (b_last && n_last && m_last) state_next = DW;
      DW:   if (m_last && n_last && b_last) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DX) || (state == DW);
    done = (state == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      bi      <= '0;
      mi      <= '0;
      ni      <= '0;
      cap_w   <= '{default: '0};
      cap_x   <= '{default: '0};
      cap_dy  <= '{default: '0};
      grad_in <= '{default: '0};
      grad_w  <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cap_w  <= weights;
            cap_x  <= inputs;
            cap_dy <= grad_out;
            acc    <= '0;
            bi     <= '0;
            mi     <= '0;
            ni     <= '0;
          end
        end
        DX: begin
          if (m_last) begin
            grad_in[bi][ni] <= result;
            acc             <= '0;
          end else begin
            acc <= sum;
          end
          mi <= m_last ? '0 : mi + 1'b1;
          if (m_last) begin
            ni <= n_last ? '0 : ni + 1'b1;
            if (n_last) bi <= b_last ? '0 : bi + 1'b1;
          end
        end
        DW: begin
          if (b_last) begin
            grad_w[mi][ni] <= result;
            acc            <= '0;
          end else begin
            acc <= sum;
          end
          bi <= b_last ? '0 : bi + 1'b1;
          if (b_last) begin
            ni <= n_last ? '0 : ni + 1'b1;
            if (n_last) mi <= m_last ? '0 : mi + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_backward.sv
// tb/tb_dense_backward.sv - scoreboard bench for dense_backward with directed vectors.
module tb_dense_backward;

  localparam int B = 2;
  localparam int M = 3;
  localparam int N = 4;
  localparam int PASS_CYCLES = 2 * B * M * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic signed [15:0] weights  [M][N];
  logic signed [15:0] inputs   [B][N];
  logic signed [15:0] grad_out [B][M];
  logic signed [15:0] grad_in  [B][N];
  logic signed [15:0] grad_w   [M][N];
  logic busy, done;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  dense_backward #(.B(B), .M(M), .N(N), .WIDTH(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .weights(weights), .inputs(inputs), .grad_out(grad_out),
    .grad_in(grad_in), .grad_w(grad_w), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the next expected result set.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() < B * N + M * N) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no result set pending (queue %0d)", exp_q.size());
      end else begin
        for (int b = 0; b < B; b++)
          for (int j = 0; j < N; j++)
            check($sformatf("grad_in[%0d][%0d]", b, j), grad_in[b][j], exp_q.pop_front());
        for (int i = 0; i < M; i++)
          for (int j = 0; j < N; j++)
            check($sformatf("grad_w[%0d][%0d]", i, j), grad_w[i][j], exp_q.pop_front());
      end
    end
  end

  task automatic set_uniform(input logic [15:0] w, input logic [15:0] x, input logic [15:0] dy);
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) weights[i][j] = w;
    for (int b = 0; b < B; b++) for (int j = 0; j < N; j++) inputs[b][j] = x;
    for (int b = 0; b < B; b++) for (int i = 0; i < M; i++) grad_out[b][i] = dy;
  endtask

  task automatic push_uniform(input logic [15:0] gi, input logic [15:0] gw);
    for (int k = 0; k < B * N; k++) exp_q.push_back(gi);
    for (int k = 0; k < M * N; k++) exp_q.push_back(gw);
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) weights[i][j] = 16'($urandom);
    for (int b = 0; b < B; b++) for (int j = 0; j < N; j++) inputs[b][j] = 16'($urandom);
    for (int b = 0; b < B; b++) for (int i = 0; i < M; i++) grad_out[b][i] = 16'($urandom);
  endtask

  function automatic logic [15:0] all_outputs_or();
    logic [15:0] r = '0;
    for (int b = 0; b < B; b++) for (int j = 0; j < N; j++) r |= grad_in[b][j];
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) r |= grad_w[i][j];
    return r;
  endfunction

  // Called at a negedge; start is accepted at the following edge k, cycle c is sampled at negedge k+c.
  task automatic run_pass(input string tag, input int stray_start_at);
    int busy_bad = 0;
    int done_bad = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
    for (int c = 1; c <= PASS_CYCLES + 2; c++) begin
      @(negedge clk);
      if (busy !== (c <= PASS_CYCLES)) busy_bad++;
      if (done !== (c == PASS_CYCLES + 1)) done_bad++;
      if (c == stray_start_at) start = 1'b1;
      if (c == stray_start_at + 1) start = 1'b0;
    end
    check({tag, "_busy_window_errors"}, 16'(busy_bad), 16'd0);
    check({tag, "_done_window_errors"}, 16'(done_bad), 16'd0);
  endtask

  int mix_gi [B][N] = '{'{14, 20, 26, 32}, '{20, 29, 38, 47}};
  int mix_gw [M][N] = '{'{3, 6, 9, 12}, '{5, 10, 15, 20}, '{7, 14, 21, 28}};

  initial begin
    set_uniform(16'h0000, 16'h0000, 16'h0000);
    #12;
    check("reset_busy", {15'd0, busy}, 16'd0);
    check("reset_done", {15'd0, done}, 16'd0);
    check("reset_outputs", all_outputs_or(), 16'd0);

    // Release and start on the very first live edge.
    @(negedge clk);
    rst_n = 1'b1;
    set_uniform(16'h0100, 16'h0200, 16'h0100);
    push_uniform(16'h0300, 16'h0400);
    run_pass("unity", 0);

    set_uniform(16'h0080, 16'h0100, 16'hFF00);
    push_uniform(16'hFE80, 16'hFE00);
    run_pass("negative", 10);

    set_uniform(16'h7FFF, 16'h0000, 16'h7FFF);
    push_uniform(16'hFD00, 16'h0000);
    run_pass("overflow", 0);

    // Index-dependent operands: W=i+j+1, X=j+1, dY=b+i+1 (all in units of 1.0).
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) weights[i][j] = 16'((i + j + 1) * 256);
    for (int b = 0; b < B; b++) for (int j = 0; j < N; j++) inputs[b][j] = 16'((j + 1) * 256);
    for (int b = 0; b < B; b++) for (int i = 0; i < M; i++) grad_out[b][i] = 16'((b + i + 1) * 256);
    for (int b = 0; b < B; b++) for (int j = 0; j < N; j++) exp_q.push_back(16'(mix_gi[b][j] * 256));
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) exp_q.push_back(16'(mix_gw[i][j] * 256));
    run_pass("mixed", 0);

    // Abort mid-pass with reset: no done, everything cleared immediately.
    set_uniform(16'h0100, 16'h0100, 16'h0100);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c < 20; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {15'd0, busy}, 16'd0);
    check("abort_done", {15'd0, done}, 16'd0);
    check("abort_outputs", all_outputs_or(), 16'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    set_uniform(16'h0100, 16'h0200, 16'h0100);
    push_uniform(16'h0300, 16'h0400);
    run_pass("after_abort", 0);

    // start held high: second pass launches on the first IDLE cycle after FIN.
    set_uniform(16'h0080, 16'h0100, 16'hFF00);
    push_uniform(16'hFE80, 16'hFE00);
    push_uniform(16'hFE80, 16'hFE00);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= PASS_CYCLES + 2; c++) begin
      @(negedge clk);
      if (c == PASS_CYCLES + 1) check("held_first_done", {15'd0, done}, 16'd1);
      if (c == PASS_CYCLES + 2) check("held_idle_gap_busy", {15'd0, busy}, 16'd0);
    end
    @(negedge clk);
    check("held_restart_busy", {15'd0, busy}, 16'd1);
    start = 1'b0;
    begin
      int waited = 0;
      while (done !== 1'b1 && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      check("held_second_done_seen", {15'd0, done}, 16'd1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
